// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection front end: pixel width and the
// feeder FSM state encoding.
package edge_pkg;

  localparam int PIXEL_W = 8;
  localparam int WINDOW_TAPS = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/gradient_window_feeder_if.sv
// Bus between the window feeder, the pixel source and the gradient engine.
// The master modport is the feeder side. o_timeout exists only when
// GRADIENT_TIMEOUT_EN is defined.
interface gradient_window_feeder_if;
  import edge_pkg::*;

  logic               i_pixel_valid;
  logic [PIXEL_W-1:0] i_pixel;
  logic               o_pixel_ready;
  logic [PIXEL_W-1:0] o_P0;
  logic [PIXEL_W-1:0] o_P1;
  logic [PIXEL_W-1:0] o_P2;
  logic [PIXEL_W-1:0] o_P3;
  logic [PIXEL_W-1:0] o_P4;
  logic [PIXEL_W-1:0] o_P5;
  logic [PIXEL_W-1:0] o_P6;
  logic [PIXEL_W-1:0] o_P7;
  logic [PIXEL_W-1:0] o_P8;
  logic               o_gradient_start;
  logic               i_gradient_data_ready;
  logic [PIXEL_W-1:0] i_processed_sum;
  logic               o_result_valid;
  logic [PIXEL_W-1:0] o_result;
  logic               o_frame_done;
`ifdef GRADIENT_TIMEOUT_EN
  logic               o_timeout;
`endif

  modport master (
`ifdef GRADIENT_TIMEOUT_EN
    output o_timeout,
`endif
    input  i_pixel_valid, i_pixel, i_gradient_data_ready, i_processed_sum,
    output o_pixel_ready, o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8,
    output o_gradient_start, o_result_valid, o_result, o_frame_done
  );

  modport slave (
`ifdef GRADIENT_TIMEOUT_EN
    input  o_timeout,
`endif
    output i_pixel_valid, i_pixel, i_gradient_data_ready, i_processed_sum,
    input  o_pixel_ready, o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8,
    input  o_gradient_start, o_result_valid, o_result, o_frame_done
  );

endinterface

// File: rtl/gradient_window_feeder_line_buffer.sv
// Two-row line buffer: a shift register of two image rows. tap_row1 is the
// pixel directly above the incoming one, tap_row2 the pixel two rows above.
module line_buffer
  import edge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic [PIXEL_W-1:0] din,
  output logic [PIXEL_W-1:0] tap_row1,
  output logic [PIXEL_W-1:0] tap_row2
);

  logic [PIXEL_W-1:0] row1 [DEPTH];
  logic [PIXEL_W-1:0] row2 [DEPTH];

  // Shift one pixel through both rows per accepted pixel; row1 spills into row2.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        row1[i] <= '0;
        row2[i] <= '0;
      end
    end else if (shift_en) begin
      row1[0] <= din;
      row2[0] <= row1[DEPTH-1];
      for (int i = 1; i < DEPTH; i++) begin
        row1[i] <= row1[i-1];
        row2[i] <= row2[i-1];
      end
    end
  end

  assign tap_row1 = row1[DEPTH-1];
  assign tap_row2 = row2[DEPTH-1];

endmodule

// File: rtl/gradient_window_feeder.sv
// Gradient window feeder: builds a 3x3 window over a raster pixel stream,
// hands each interior window to the gradient engine and returns its result.
// Optional feature macro: GRADIENT_TIMEOUT_EN (bounded WAIT with o_timeout).
module gradient_window_feeder
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH      = 8,
  parameter int IMG_HEIGHT     = 8,
  parameter int TIMEOUT_CYCLES = 40
) (
  input logic                      clk,
  input logic                      rst,
  gradient_window_feeder_if.master bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  if (IMG_WIDTH < 3 || IMG_WIDTH > 255) begin : g_bad_width
    $error("IMG_WIDTH must be within 3..255");
  end
  if (IMG_HEIGHT < 3 || IMG_HEIGHT > 255) begin : g_bad_height
    $error("IMG_HEIGHT must be within 3..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  feeder_state_t      state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [PIXEL_W-1:0] win [WINDOW_TAPS];
  logic [PIXEL_W-1:0] tap_row1;
  logic [PIXEL_W-1:0] tap_row2;
  logic               accept;
  logic               interior;
  logic               last_win;
  logic               start_q;
  logic               valid_q;
  logic               done_q;
  logic [PIXEL_W-1:0] result_q;

`ifdef GRADIENT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
`endif

  // Pixels are only taken while idle; the window is frozen during a request.
  assign bus.o_pixel_ready = (state == IDLE) && !rst;
  assign accept   = bus.i_pixel_valid && bus.o_pixel_ready;
  assign interior = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (bus.i_pixel),
    .tap_row1 (tap_row1),
    .tap_row2 (tap_row2)
  );

  // Raster position of the next pixel, wrapping at row and frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shift the 3x3 window left and load the new right column from the taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WINDOW_TAPS; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= tap_row2;
      win[5] <= tap_row1;
      win[8] <= bus.i_pixel;
    end
  end

  // Request/response FSM with registered strobes and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      last_win <= 1'b0;
`ifdef GRADIENT_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef GRADIENT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept && interior) begin
            state    <= START;
            start_q  <= 1'b1;
            last_win <= (row == ROW_LAST) && (col == COL_LAST);
          end
        end
        START: begin
          state <= WAIT;
`ifdef GRADIENT_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.i_gradient_data_ready) begin
            state    <= OUTPUT;
            result_q <= bus.i_processed_sum;
            valid_q  <= 1'b1;
            done_q   <= last_win;
          end
`ifdef GRADIENT_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state     <= OUTPUT;
            result_q  <= '0;
            valid_q   <= 1'b1;
            done_q    <= last_win;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        OUTPUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_gradient_start = start_q;
  assign bus.o_result_valid   = valid_q;
  assign bus.o_frame_done     = done_q;
  assign bus.o_result         = result_q;
`ifdef GRADIENT_TIMEOUT_EN
  assign bus.o_timeout        = timeout_q;
`endif

  assign bus.o_P0 = win[0];
  assign bus.o_P1 = win[1];
  assign bus.o_P2 = win[2];
  assign bus.o_P3 = win[3];
  assign bus.o_P4 = win[4];
  assign bus.o_P5 = win[5];
  assign bus.o_P6 = win[6];
  assign bus.o_P7 = win[7];
  assign bus.o_P8 = win[8];

endmodule
